// File: rtl/out_sel_decode_if.sv
// out_sel_decode_if: flit/select handshake bundle between route computation,
// the select decoder and the crossbar enable logic.
// master = the side that presents flits and accepts allocations,
// slave  = the decoder itself.
interface out_sel_decode_if #(
    parameter int NUM_PORT     = 6,
    parameter int LOG_NUM_PORT = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LOG_NUM_PORT-1:0] in_sel;
    logic                    in_head;
    logic                    in_tail;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_PORT-1:0]     out_alloc;
    logic                    out_tail;

    modport master (
        output in_valid, in_sel, in_head, in_tail, out_ready,
        input  in_ready, out_valid, out_alloc, out_tail
    );

    modport slave (
        input  in_valid, in_sel, in_head, in_tail, out_ready,
        output in_ready, out_valid, out_alloc, out_tail
    );
endinterface

// File: rtl/out_sel_decode.sv
// out_sel_decode: turns the binary output-port index carried on a head flit
// into a one-hot allocation vector, holding that vector for the body and
// tail flits of the same packet. One registered valid/ready stage.
// Optional feature: define OUT_SEL_DEC_RANGE_CHECK_EN to drop heads whose
// index is not a real port (flagging err_range) along with the rest of
// that packet.
module out_sel_decode #(
    parameter int NUM_PORT     = 6,
    parameter int LOG_NUM_PORT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    out_sel_decode_if.slave  bus,
    output logic             lock_busy,
    output logic             err_proto,
    output logic             err_range
);

    // DROP is only reachable when the range check is built in: it swallows
    // the remainder of a packet whose head was rejected.
    typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;

    localparam logic [LOG_NUM_PORT:0] PORT_LIMIT = (LOG_NUM_PORT + 1)'(NUM_PORT);

    state_t              state;
    state_t              state_next;
    logic [NUM_PORT-1:0] lock_reg;
    logic [NUM_PORT-1:0] lock_next;
    logic [NUM_PORT-1:0] decoded;
    logic [NUM_PORT-1:0] emit_alloc;
    logic                transfer;
    logic                emit;
    logic                set_proto;
    logic                sel_ok;
    logic                range_drop;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign transfer     = bus.in_valid && bus.in_ready;
    assign sel_ok       = {1'b0, bus.in_sel} < PORT_LIMIT;
    assign decoded      = sel_ok ? (NUM_PORT'(1) << bus.in_sel) : '0;
    assign lock_busy    = (state == LOCK);

`ifdef OUT_SEL_DEC_RANGE_CHECK_EN
    assign range_drop = !sel_ok;
`else
    assign range_drop = 1'b0;
`endif

    // Packet state and the held port vector; both move only on a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lock_reg <= '0;
        end else begin
            state    <= state_next;
            lock_reg <= lock_next;
        end
    end

    // Next state, what (if anything) to emit, and protocol error detection.
    always_comb begin
        state_next = state;
        lock_next  = lock_reg;
        emit       = 1'b0;
        emit_alloc = lock_reg;
        set_proto  = 1'b0;
        if (transfer) begin
            if (bus.in_head) begin
                if (state == LOCK) begin
                    set_proto = 1'b1;
                end
                if (range_drop) begin
                    state_next = bus.in_tail ? IDLE : DROP;
                end else begin
                    emit       = 1'b1;
                    emit_alloc = decoded;
                    if (bus.in_tail) begin
                        state_next = IDLE;
                    end else begin
                        state_next = LOCK;
                        lock_next  = decoded;
                    end
                end
            end else begin
                case (state)
                    LOCK: begin
                        emit = 1'b1;
                        if (bus.in_tail) begin
                            state_next = IDLE;
                        end
                    end
                    DROP: begin
                        if (bus.in_tail) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        set_proto = 1'b1;
                    end
                endcase
            end
        end
    end

    // Output stage: load on an emitting transfer, retire when downstream takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_alloc <= '0;
            bus.out_tail  <= 1'b0;
        end else if (emit) begin
            bus.out_valid <= 1'b1;
            bus.out_alloc <= emit_alloc;
            bus.out_tail  <= bus.in_tail;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_proto <= 1'b0;
        end else if (set_proto) begin
            err_proto <= 1'b1;
        end
    end

`ifdef OUT_SEL_DEC_RANGE_CHECK_EN
    // Sticky flag for a head naming a port that does not exist.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_range <= 1'b0;
        end else if (transfer && bus.in_head && range_drop) begin
            err_range <= 1'b1;
        end
    end
`else
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_out_sel_decode.sv
// tb_out_sel_decode: directed scenarios with literal expectations followed by
// randomized packet traffic, all checked every cycle against a packet-level
// reference model. Honours OUT_SEL_DEC_RANGE_CHECK_EN.
module tb_out_sel_decode;

    localparam int NUM_PORT     = 6;
    localparam int LOG_NUM_PORT = 3;
`ifdef OUT_SEL_DEC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic lock_busy;
    logic err_proto;
    logic err_range;

    int checks = 0;
    int errors = 0;

    out_sel_decode_if #(.NUM_PORT(NUM_PORT), .LOG_NUM_PORT(LOG_NUM_PORT)) bus ();

    out_sel_decode #(.NUM_PORT(NUM_PORT), .LOG_NUM_PORT(LOG_NUM_PORT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .lock_busy (lock_busy),
        .err_proto (err_proto),
        .err_range (err_range)
    );

    always #5 clk = ~clk;

    // Reference model: "is a packet open", "is a rejected packet being skipped",
    // the port that packet owns, and the pending output word.
    typedef struct packed {
        bit                  open;
        bit                  skip;
        logic [NUM_PORT-1:0] port;
        bit                  ov;
        logic [NUM_PORT-1:0] alloc;
        bit                  tail;
        bit                  ep;
        bit                  er;
    } model_t;

    model_t m = '0;

    function automatic logic [NUM_PORT-1:0] one_hot(int sel);
        logic [NUM_PORT-1:0] v = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (i == sel) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic model_t model_step(model_t cur, bit v, int sel, bit h, bit t, bit rdy);
        model_t              nxt = cur;
        bit                  emit = 1'b0;
        logic [NUM_PORT-1:0] a = '0;
        if (!(v && (!cur.ov || rdy))) begin
            if (rdy) nxt.ov = 1'b0;
            return nxt;
        end
        if (h) begin
            if (cur.open) nxt.ep = 1'b1;
            nxt.open = 1'b0;
            nxt.skip = 1'b0;
            if (RC && sel >= NUM_PORT) begin
                nxt.er   = 1'b1;
                nxt.skip = !t;
            end else begin
                emit = 1'b1;
                a    = one_hot(sel);
                if (!t) begin
                    nxt.open = 1'b1;
                    nxt.port = a;
                end
            end
        end else if (cur.skip) begin
            if (t) nxt.skip = 1'b0;
        end else if (!cur.open) begin
            nxt.ep = 1'b1;
        end else begin
            emit = 1'b1;
            a    = cur.port;
            if (t) nxt.open = 1'b0;
        end
        if (emit) begin
            nxt.ov    = 1'b1;
            nxt.alloc = a;
            nxt.tail  = t;
        end else if (rdy) begin
            nxt.ov = 1'b0;
        end
        return nxt;
    endfunction

    // Advance the model on each clock edge, clear it on reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0;
        end else begin
            m <= model_step(m, bus.in_valid, int'(bus.in_sel), bus.in_head, bus.in_tail, bus.out_ready);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checkOutput("out_valid", bus.out_valid, m.ov);
            if (m.ov) begin
                checkOutput("out_alloc", bus.out_alloc, m.alloc);
                checkOutput("out_tail", bus.out_tail, m.tail);
            end
            checkOutput("in_ready", bus.in_ready, !m.ov || bus.out_ready);
            checkOutput("lock_busy", lock_busy, m.open);
            checkOutput("err_proto", err_proto, m.ep);
            checkOutput("err_range", err_range, m.er);
        end
    end

    task automatic applyStimulus(input bit v, input int sel, input bit h, input bit t, input bit rdy);
        @(negedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_sel    = sel[LOG_NUM_PORT-1:0];
        bus.in_head   = h;
        bus.in_tail   = t;
        bus.out_ready = rdy;
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, rdy);
    endtask

    task automatic sendFlit(input int sel, input bit h, input bit t, input bit rdy, input bit rnd);
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b1, sel, h, t, rnd ? 1'($urandom_range(0, 1)) : rdy);
            if (!m.ov || bus.out_ready) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL handshake_timeout: flit not accepted in 64 cycles, required acceptance");
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        int sel;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_head   = 1'b0;
        bus.in_tail   = 1'b0;
        bus.out_ready = 1'b1;
        doReset();
        #1;
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_alloc", bus.out_alloc, 0);
        checkOutput("rst_lock", lock_busy, 0);
        checkOutput("rst_err", {err_proto, err_range}, 0);

        // Single-flit packet to port 3.
        sendFlit(3, 1, 1, 1, 0);
        idle(1);
        #1;
        checkOutput("t1_valid", bus.out_valid, 1);
        checkOutput("t1_alloc", bus.out_alloc, 6'b001000);
        checkOutput("t1_tail", bus.out_tail, 1);
        checkOutput("t1_lock", lock_busy, 0);

        // Four-flit packet to port 5; tail's sel is ignored.
        sendFlit(5, 1, 0, 1, 0);
        sendFlit(0, 0, 0, 1, 0);
        #1;
        checkOutput("t2_head_alloc", bus.out_alloc, 6'b100000);
        checkOutput("t2_head_lock", lock_busy, 1);
        sendFlit(2, 0, 0, 1, 0);
        #1;
        checkOutput("t2_body1_alloc", bus.out_alloc, 6'b100000);
        sendFlit(0, 0, 1, 1, 0);
        #1;
        checkOutput("t2_body2_alloc", bus.out_alloc, 6'b100000);
        checkOutput("t2_body2_lock", lock_busy, 1);
        idle(1);
        #1;
        checkOutput("t2_tail_alloc", bus.out_alloc, 6'b100000);
        checkOutput("t2_tail_flag", bus.out_tail, 1);
        checkOutput("t2_tail_lock", lock_busy, 0);

        // Downstream stall for three cycles, then release with no bubble.
        sendFlit(2, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4, 1, 1, 0);
            #1;
            checkOutput("t3_stall_ready", bus.in_ready, 0);
            checkOutput("t3_stall_alloc", bus.out_alloc, 6'b000100);
        end
        applyStimulus(1, 4, 1, 1, 1);
        #1;
        checkOutput("t3_release_ready", bus.in_ready, 1);
        idle(1);
        #1;
        checkOutput("t3_next_valid", bus.out_valid, 1);
        checkOutput("t3_next_alloc", bus.out_alloc, 6'b010000);

        // Stray body in IDLE, then a head arriving mid-packet.
        doReset();
        sendFlit(0, 0, 0, 1, 0);
        idle(1);
        #1;
        checkOutput("t4_stray_err", err_proto, 1);
        checkOutput("t4_stray_valid", bus.out_valid, 0);
        doReset();
        sendFlit(4, 1, 0, 1, 0);
        sendFlit(0, 0, 0, 1, 0);
        #1;
        checkOutput("t4_clean_err", err_proto, 0);
        sendFlit(1, 1, 0, 1, 0);
        idle(1);
        #1;
        checkOutput("t4_relock_err", err_proto, 1);
        checkOutput("t4_relock_alloc", bus.out_alloc, 6'b000010);
        checkOutput("t4_relock_lock", lock_busy, 1);
        sendFlit(0, 0, 1, 1, 0);
        idle(1);

        // Out-of-range head, then an out-of-range multi-flit packet.
        doReset();
        sendFlit(7, 1, 1, 1, 0);
        idle(1);
        #1;
        checkOutput("t5_range_err", err_range, RC ? 1 : 0);
        checkOutput("t5_range_valid", bus.out_valid, RC ? 0 : 1);
        if (!RC) checkOutput("t5_range_alloc", bus.out_alloc, 0);
        checkOutput("t5_range_lock", lock_busy, 0);
        sendFlit(6, 1, 0, 1, 0);
        sendFlit(0, 0, 0, 1, 0);
        sendFlit(0, 0, 1, 1, 0);
        idle(1);
        #1;
        checkOutput("t5_pkt_proto", err_proto, 0);
        checkOutput("t5_pkt_valid", bus.out_valid, RC ? 0 : 1);
        sendFlit(3, 1, 1, 1, 0);
        idle(1);
        #1;
        checkOutput("t5_after_alloc", bus.out_alloc, 6'b001000);

        // Reset asserted mid-packet while an output is pending.
        doReset();
        sendFlit(2, 1, 0, 0, 0);
        idle(0);
        #1;
        checkOutput("t6_pre_valid", bus.out_valid, 1);
        checkOutput("t6_pre_lock", lock_busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", bus.out_valid, 0);
        checkOutput("t6_rst_alloc", bus.out_alloc, 0);
        checkOutput("t6_rst_lock", lock_busy, 0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        sendFlit(0, 0, 0, 1, 0);
        idle(1);
        #1;
        checkOutput("t6_body_err", err_proto, 1);
        checkOutput("t6_body_valid", bus.out_valid, 0);

        // Randomized packet traffic with random back-pressure and gaps.
        doReset();
        for (int p = 0; p < 200; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                sendFlit(int'($urandom_range(0, 7)), 0, 1'($urandom_range(0, 1)), 0, 1);
            end else begin
                len = int'($urandom_range(1, 4));
                sel = int'($urandom_range(0, 7));
                if (len == 1) begin
                    sendFlit(sel, 1, 1, 0, 1);
                end else begin
                    sendFlit(sel, 1, 0, 0, 1);
                    for (int b = 0; b < len - 2; b++) begin
                        sendFlit(int'($urandom_range(0, 7)), 0, 0, 0, 1);
                        if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
                    end
                    sendFlit(int'($urandom_range(0, 7)), 0, 1, 0, 1);
                end
            end
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
        end
        repeat (4) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
